max_pool_stream: RTL and testbench

MAX_POOL_STREAM -- requirements
Module: max_pool_stream

---
 rtl/max_pool_stream_if.sv | 10 +
 rtl/max_pool_stream.sv | 103 ++++++++++
 tb/tb_max_pool_stream.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/max_pool_stream_if.sv
// Valid/ready stream carrying real-valued samples with an end-of-frame marker.
interface max_pool_stream_if;
  logic valid;
  real  data;
  logic last;
  logic ready;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/max_pool_stream.sv
// Streaming 2x2 stride-2 max pooling with optional ReLU; input is channel-major,
// then row, then column. A one-row line buffer holds partial window maxima.
module max_pool_stream #(
  parameter int unsigned MAXW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                relu,
  input  logic [3:0]          ch,
  input  logic [4:0]          ih,
  input  logic [4:0]          iw,
  max_pool_stream_if.slave    s,
  max_pool_stream_if.master   m,
  output logic                err
);

  localparam int unsigned AW = (MAXW > 1) ? $clog2(MAXW) : 1;

  logic [4:0]    col;
  logic [4:0]    row;
  logic [3:0]    chn;
  real           line_buf [MAXW];

  logic [AW-1:0] p;
  logic          s_fire;
  logic          at_final;
  logic          first_pos;
  logic          win_end;
  real           buf_rd;
  real           pooled;
  real           pooled_act;

  // Window position decode and the running max for the current beat
  always_comb begin
    p          = AW'(col >> 1);
    s_fire     = s.valid && s.ready;
    at_final   = (col == iw) && (row == ih) && (chn == ch);
    first_pos  = !row[0] && !col[0];
    win_end    = row[0] && col[0];
    buf_rd     = line_buf[p];
    pooled     = (s.data > buf_rd) ? s.data : buf_rd;
    pooled_act = (relu && (pooled < 0.0)) ? 0.0 : pooled;
  end

  assign s.ready = !m.valid || m.ready;

  // Line buffer is always seeded at even/even before use, so it carries no reset
  always_ff @(posedge clk) begin
    if (s_fire && !clr) begin
      line_buf[p] <= first_pos ? s.data : pooled;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      chn     <= '0;
      m.valid <= 1'b0;
      m.last  <= 1'b0;
      m.data  <= 0.0;
      err     <= 1'b0;
    end else if (clr) begin
      col     <= '0;
      row     <= '0;
      chn     <= '0;
      m.valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (m.valid && m.ready) begin
        m.valid <= 1'b0;
      end
      if (s_fire) begin
        if (win_end) begin
          m.valid <= 1'b1;
          m.data  <= pooled_act;
          m.last  <= at_final;
        end
        // Early s_last or a missing s_last at the final position are both framing errors
        if (s.last != at_final) begin
          err <= 1'b1;
        end
        if (s.last || at_final) begin
          col <= '0;
          row <= '0;
          chn <= '0;
        end else if (col == iw) begin
          col <= '0;
          if (row == ih) begin
            row <= '0;
            chn <= (chn == ch) ? 4'd0 : chn + 4'd1;
          end else begin
            row <= row + 5'd1;
          end
        end else begin
          col <= col + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream: a frame-level pooling model fills an
// expectation queue that one monitor process drains against the output stream.
module tb_max_pool_stream;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr   = 1'b0;
  logic       relu  = 1'b0;
  logic [3:0] ch    = 4'd0;
  logic [4:0] ih    = 5'd1;
  logic [4:0] iw    = 5'd1;
  logic       err;

  max_pool_stream_if s_if ();
  max_pool_stream_if m_if ();

  max_pool_stream #(.MAXW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .relu  (relu),
    .ch    (ch),
    .ih    (ih),
    .iw    (iw),
    .s     (s_if),
    .m     (m_if),
    .err   (err)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  real exp_d [$];
  bit  exp_l [$];
  real vin [512];

  task automatic chk_r(input string name, input real act, input real req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %f, expected %f (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame-level model: max over each 2x2 block, ReLU, last on the final block
  task automatic model_frame();
    int  w;
    int  h;
    int  base;
    real v [4];
    real mx;
    w = int'(iw) + 1;
    h = int'(ih) + 1;
    for (int c = 0; c <= int'(ch); c++) begin
      for (int r = 0; r < h; r += 2) begin
        for (int x = 0; x < w; x += 2) begin
          base = c * h * w;
          v[0] = vin[base + r * w + x];
          v[1] = vin[base + r * w + x + 1];
          v[2] = vin[base + (r + 1) * w + x];
          v[3] = vin[base + (r + 1) * w + x + 1];
          mx = v[0];
          for (int k = 1; k < 4; k++) if (v[k] > mx) mx = v[k];
          if (relu && mx < 0.0) mx = 0.0;
          exp_d.push_back(mx);
          exp_l.push_back((c == int'(ch)) && (r + 2 == h) && (x + 2 == w));
        end
      end
    end
  endtask

  task automatic set_vin4(input real a, input real b, input real c, input real d);
    vin[0] = a; vin[1] = b; vin[2] = c; vin[3] = d;
  endtask

  task automatic send(input real d, input bit l, inout int waits);
    int w;
    @(negedge clk);
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = l;
    #1;
    w = 0;
    while (!s_if.ready && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!s_if.ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: s_ready stuck at 0 for %0d cycles", w);
    end
    waits += w;
    @(posedge clk);
  endtask

  task automatic send_frame(input int n, input int last_at, output int waits);
    waits = 0;
    for (int i = 0; i < n; i++) send(vin[i], (i == last_at), waits);
    @(negedge clk);
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_d.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    #4;
    chk_i("drain_queue_empty", exp_d.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_i({tag, "_m_valid"}, int'(m_if.valid), 0);
    chk_i({tag, "_m_last"}, int'(m_if.last), 0);
    chk_r({tag, "_m_data"}, m_if.data, 0.0);
    chk_i({tag, "_err"}, int'(err), 0);
    chk_i({tag, "_s_ready"}, int'(s_if.ready), 1);
  endtask

  // Output monitor: pops one expectation per transfer, enforces hold-while-stalled
  bit   stalled = 1'b0;
  real  held_d;
  logic held_l;
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      chk_i("s_ready_rule", int'(s_if.ready), int'(!m_if.valid || m_if.ready));
      if (stalled) begin
        chk_i("stall_valid_held", int'(m_if.valid), 1);
        chk_r("stall_data_held", m_if.data, held_d);
        chk_i("stall_last_held", int'(m_if.last), int'(held_l));
      end
      stalled = 1'b0;
      if (m_if.valid) begin
        if (m_if.ready) begin
          if (exp_d.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: data %f last %0d", m_if.data, m_if.last);
          end else begin
            chk_r("out_data", m_if.data, exp_d.pop_front());
            chk_i("out_last", int'(m_if.last), int'(exp_l.pop_front()));
          end
        end else begin
          stalled = 1'b1;
          held_d  = m_if.data;
          held_l  = m_if.last;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  waits;
    int  cnt;
    int  guard;
    real pin32 [8];
    pin32 = '{5.0, 7.0, 13.0, 15.0, 21.0, 23.0, 29.0, 31.0};

    s_if.valid = 1'b0;
    s_if.data  = 0.0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single 2x2 window, output one clock after the closing beat
    ch = 4'd0; ih = 5'd1; iw = 5'd1; relu = 1'b0;
    set_vin4(1.0, 4.0, -2.0, 3.0);
    model_frame();
    chk_r("pin_model_2x2", exp_d[0], 4.0);
    chk_i("pin_model_2x2_last", int'(exp_l[0]), 1);
    send_frame(4, 3, waits);
    #3;
    chk_i("single_latency_valid", int'(m_if.valid), 1);
    chk_r("single_latency_data", m_if.data, 4.0);
    chk_i("single_latency_last", int'(m_if.last), 1);
    chk_i("single_err", int'(err), 0);
    drain();

    // Two channels of 4x4, values 0..31
    ch = 4'd1; ih = 5'd3; iw = 5'd3;
    for (int i = 0; i < 32; i++) vin[i] = real'(i);
    model_frame();
    chk_i("pin_model_4x4_count", exp_d.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk_r("pin_model_4x4_data", exp_d[k], pin32[k]);
      chk_i("pin_model_4x4_last", int'(exp_l[k]), int'(k == 7));
    end
    send_frame(32, 31, waits);
    chk_i("full_rate_no_backpressure", waits, 0);
    drain();
    chk_i("4x4_err", int'(err), 0);

    // ReLU on/off with an all-negative window
    ch = 4'd0; ih = 5'd1; iw = 5'd1;
    set_vin4(-1.0, -1.0, -1.0, -1.0);
    model_frame();
    chk_r("pin_model_norelu", exp_d[0], -1.0);
    send_frame(4, 3, waits);
    drain();
    relu = 1'b1;
    model_frame();
    chk_r("pin_model_relu", exp_d[0], 0.0);
    send_frame(4, 3, waits);
    drain();
    relu = 1'b0;

    // Downstream stall of 5 cycles on the first output
    ch = 4'd1; ih = 5'd3; iw = 5'd3;
    for (int i = 0; i < 32; i++) vin[i] = real'(i);
    model_frame();
    m_if.ready = 1'b0;
    fork
      send_frame(32, 31, waits);
      begin
        cnt = 0;
        guard = 0;
        while (cnt < 5 && guard < 300) begin
          @(negedge clk);
          guard++;
          if (m_if.valid) begin
            #1;
            chk_i("stall_s_ready_low", int'(s_if.ready), 0);
            chk_r("stall_data_is_5", m_if.data, 5.0);
            cnt++;
          end
        end
        chk_i("stall_observed", cnt, 5);
        @(negedge clk);
        m_if.ready = 1'b1;
      end
    join
    drain();

    // Early s_last: error, no output, next frame still pools, err sticky until clr
    ch = 4'd0; ih = 5'd1; iw = 5'd1;
    set_vin4(9.0, 9.0, 9.0, 9.0);
    send_frame(3, 2, waits);
    #3;
    chk_i("early_last_err", int'(err), 1);
    chk_i("early_last_no_output", int'(m_if.valid), 0);
    set_vin4(2.0, -5.0, 7.0, 1.0);
    model_frame();
    send_frame(4, 3, waits);
    drain();
    chk_i("err_sticky", int'(err), 1);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    #3 chk_i("clr_err", int'(err), 0);

    // Missing s_last at the final position: err sets, m_last still produced
    set_vin4(3.0, 3.0, 6.0, 3.0);
    model_frame();
    send_frame(4, -1, waits);
    drain();
    chk_i("missing_last_err", int'(err), 1);
    set_vin4(-4.0, -8.0, -6.0, -7.0);
    model_frame();
    chk_r("pin_model_neg", exp_d[0], -4.0);
    send_frame(4, 3, waits);
    drain();

    // clr wins over a simultaneous transfer, which is dropped
    @(negedge clk);
    clr = 1'b1;
    s_if.valid = 1'b1;
    s_if.data  = 100.0;
    s_if.last  = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    s_if.valid = 1'b0;
    #3 chk_i("clr_err_again", int'(err), 0);
    set_vin4(1.0, 2.0, 3.0, 4.0);
    model_frame();
    send_frame(4, 3, waits);
    drain();

    // Reset with an output pending and err set
    m_if.ready = 1'b0;
    set_vin4(1.0, 2.0, 3.0, 8.0);
    send_frame(4, -1, waits);
    #1 chk_i("pre_reset_pending", int'(m_if.valid), 1);
    rst_n = 1'b0;
    #1 check_reset_outputs("abort_reset");
    exp_d.delete();
    exp_l.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_if.ready = 1'b1;

    // Reset after two beats: next four beats form a fresh window
    set_vin4(5.0, 6.0, 0.0, 0.0);
    send_frame(2, -1, waits);
    rst_n = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_vin4(1.0, -3.0, 2.0, 0.0);
    model_frame();
    chk_r("pin_model_fresh", exp_d[0], 2.0);
    send_frame(4, 3, waits);
    drain();
    chk_i("fresh_err", int'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
